// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state type and decoded-control bundle for cpu_seq.
// CPU_SEQ_SINGLE_STEP_EN adds the PAUSE state used for single-stepping.
package cpu_pkg;

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDAD = 4'd2;
    localparam logic [3:0] OP_LDBD = 4'd3;
    localparam logic [3:0] OP_ALU  = 4'd4;
    localparam logic [3:0] OP_ALUS = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_JMPX = 4'd7;
    localparam logic [3:0] OP_JC   = 4'd8;
    localparam logic [3:0] OP_JNC  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_JNZ  = 4'd11;
    localparam logic [3:0] OP_HLT  = 4'd12;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
`ifdef CPU_SEQ_SINGLE_STEP_EN
        PAUSE = 2'd3,
`endif
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic aload;
        logic bload;
        logic dsel;
        logic rfload;
        logic opsel;
        logic jump;
        logic halt;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: 1'b0};

    function automatic logic [3:0] pc_inc(input logic [3:0] p);
        return p + 4'd1;
    endfunction

endpackage

// File: rtl/cpu_seq_if.sv
// Instruction-memory fetch bus between cpu_seq (master) and the memory (slave).
interface cpu_seq_if;

    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);

endinterface

// File: rtl/ins_dec.sv
// Instruction decoder: opcode plus registered flags to datapath control.
module ins_dec
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output ctrl_t      ctrl
);

    // Decode table; conditional jumps resolve against the stored flags.
    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            OP_LDA:  ctrl.aload = 1'b1;
            OP_LDB:  ctrl.bload = 1'b1;
            OP_LDAD: begin
                ctrl.aload = 1'b1;
                ctrl.dsel  = 1'b1;
            end
            OP_LDBD: begin
                ctrl.bload = 1'b1;
                ctrl.dsel  = 1'b1;
            end
            OP_ALU:  ctrl.rfload = 1'b1;
            OP_ALUS: begin
                ctrl.rfload = 1'b1;
                ctrl.opsel  = 1'b1;
            end
            OP_JMP:  ctrl.jump = 1'b1;
            OP_JMPX: ctrl.jump = 1'b1;
            OP_JC:   ctrl.jump = carry;
            OP_JNC:  ctrl.jump = ~carry;
            OP_JZ:   ctrl.jump = zero;
            OP_JNZ:  ctrl.jump = ~zero;
            OP_HLT:  ctrl.halt = 1'b1;
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/cpu_seq.sv
// Fetch/execute sequencer for a 4-bit-address CPU; decode lives in ins_dec.
// Define CPU_SEQ_SINGLE_STEP_EN to add the step input and PAUSE state.
module cpu_seq
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    cpu_seq_if.master  imem,
    input  logic       alu_carry,
    input  logic       alu_zero,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       aload,
    output logic       bload,
    output logic       dsel,
    output logic       rfload,
    output logic       opsel,
    output logic       str,
    output logic [3:0] operand,
    output logic [3:0] pc,
    output logic       halted
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] pc_r;
    logic [3:0] pc_nxt_s;
    logic [7:0] ir_r;
    logic       carry_r;
    logic       zero_r;
    logic       run_r;
    logic       fetch_done_s;
    logic       exec_s;
    ctrl_t      ctrl_s;

    ins_dec u_ins_dec (
        .opcode (ir_r[7:4]),
        .carry  (carry_r),
        .zero   (zero_r),
        .ctrl   (ctrl_s)
    );

    // run_r keeps the request low for the partial cycle after reset release,
    // so a stale acknowledge from an abandoned fetch cannot be taken.
    assign fetch_done_s = run_r && (state_r == FETCH) && imem.imem_ack;
    assign exec_s       = (state_r == EXEC);

    // State, PC, instruction register and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            pc_r    <= 4'd0;
            ir_r    <= 8'd0;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            run_r   <= 1'b1;
            if (fetch_done_s) begin
                ir_r <= imem.imem_data;
            end else begin
                ir_r <= ir_r;
            end
            if (exec_s && ctrl_s.rfload) begin
                carry_r <= alu_carry;
                zero_r  <= alu_zero;
            end else begin
                carry_r <= carry_r;
                zero_r  <= zero_r;
            end
        end
    end

    // Next-state and next-PC logic.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        case (state_r)
            FETCH: begin
                if (fetch_done_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            EXEC: begin
                if (ctrl_s.halt) begin
                    state_nxt_s = HALT;
                    pc_nxt_s    = pc_r;
                end else begin
                    if (ctrl_s.jump) begin
                        pc_nxt_s = ir_r[3:0];
                    end else begin
                        pc_nxt_s = pc_inc(pc_r);
                    end
`ifdef CPU_SEQ_SINGLE_STEP_EN
                    state_nxt_s = PAUSE;
`else
                    state_nxt_s = FETCH;
`endif
                end
            end
            HALT: state_nxt_s = HALT;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            PAUSE: begin
                if (step) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
`endif
            default: begin
                state_nxt_s = FETCH;
                pc_nxt_s    = pc_r;
            end
        endcase
    end

    assign imem.imem_req  = run_r && (state_r == FETCH);
    assign imem.imem_addr = pc_r;

    assign aload   = exec_s & ctrl_s.aload;
    assign bload   = exec_s & ctrl_s.bload;
    assign dsel    = exec_s & ctrl_s.dsel;
    assign rfload  = exec_s & ctrl_s.rfload;
    assign opsel   = exec_s & ctrl_s.opsel;
    assign str     = exec_s & (ctrl_s.jump | ctrl_s.halt);
    assign operand = ir_r[3:0];
    assign pc      = pc_r;
    assign halted  = (state_r == HALT);

endmodule

// File: tb/tb_cpu_seq.sv
// Directed self-checking bench for cpu_seq with a delay-programmable memory responder.
module tb_cpu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic       aload, bload, dsel, rfload, opsel, str, halted;
    logic [3:0] operand, pc;

    cpu_seq_if imem ();

    cpu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (imem.master),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step      (step),
`endif
        .aload     (aload),
        .bload     (bload),
        .dsel      (dsel),
        .rfload    (rfload),
        .opsel     (opsel),
        .str       (str),
        .operand   (operand),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    int         ack_delay = 0;
    int         wait_cnt = 0;
    logic       late_ack = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    // Memory responder: ack after ack_delay request cycles; late_ack models a stale ack.
    initial begin
        imem.imem_ack  = 1'b0;
        imem.imem_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (late_ack) begin
                imem.imem_ack  = 1'b1;
                imem.imem_data = 8'hC0;
                wait_cnt       = 0;
            end else if (!imem.imem_req) begin
                imem.imem_ack = 1'b0;
                wait_cnt      = 0;
            end else begin
                imem.imem_ack  = (wait_cnt >= ack_delay);
                imem.imem_data = mem[imem.imem_addr];
                wait_cnt       = wait_cnt + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {aload, bload, dsel, rfload, opsel, str};
    endfunction

    // Reset with a stale ack present; returns at the negedge of the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        late_ack = 1'b1;
        #1;
        check_val("rst_req", imem.imem_req, 1'b0);
        check_val("rst_pc", pc, 4'd0);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_strobes", strobes(), 6'b000000);
        check_val("rst_operand", operand, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("rst_hold_req", imem.imem_req, 1'b0);
        check_val("rst_hold_pc", pc, 4'd0);
        late_ack = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic obs_fetch(input string tag, input logic [3:0] addr);
        check_val({tag, "_req"}, imem.imem_req, 1'b1);
        check_val({tag, "_addr"}, imem.imem_addr, addr);
        check_val({tag, "_pc"}, pc, addr);
        check_val({tag, "_strb"}, strobes(), 6'b000000);
        @(negedge clk);
    endtask

    task automatic obs_exec(input string tag, input logic [5:0] s, input logic [3:0] opnd);
        check_val({tag, "_req"}, imem.imem_req, 1'b0);
        check_val({tag, "_strb"}, strobes(), s);
        check_val({tag, "_opnd"}, operand, opnd);
        check_val({tag, "_halted"}, halted, 1'b0);
        @(negedge clk);
    endtask

    logic [3:0] sweep_op [16];
    logic [5:0] sweep_exp [16];

    initial begin
        // Decode sweep, one instruction per address; jump targets equal pc+1.
        sweep_op = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                     4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0};
        sweep_exp = '{6'b100000, 6'b010000, 6'b101000, 6'b011000,
                      6'b000100, 6'b000110, 6'b000001, 6'b000001,
                      6'b000000, 6'b000001, 6'b000000, 6'b000001,
                      6'b000000, 6'b000000, 6'b000000, 6'b100000};
        for (int k = 0; k < 16; k++) begin
            mem[k] = {sweep_op[k], 4'(k + 1)};
        end
        do_reset();
        for (int k = 0; k < 16; k++) begin
            obs_fetch($sformatf("sweep_f%0d", k), 4'(k));
            obs_exec($sformatf("sweep_e%0d", k), sweep_exp[k], 4'(k + 1));
        end
        obs_fetch("wrap_f0", 4'd0);

        // Slow memory: request held four cycles, aload pulses once.
        for (int k = 0; k < 16; k++) mem[k] = 8'hD0;
        mem[0]    = 8'h05;
        ack_delay = 3;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("slow_req%0d", k), imem.imem_req, 1'b1);
            check_val($sformatf("slow_aload%0d", k), aload, 1'b0);
            @(negedge clk);
        end
        obs_exec("slow_e0", 6'b100000, 4'd5);
        check_val("slow_aload_end", aload, 1'b0);
        check_val("slow_pc", pc, 4'd1);

        // Fetch abandoned by reset; the restart fetches address 0 afresh.
        ack_delay = 10;
        do_reset();
        check_val("abandon_req", imem.imem_req, 1'b1);
        @(negedge clk);
        ack_delay = 0;
        do_reset();
        obs_fetch("abandon_f0", 4'd0);
        obs_exec("abandon_e0", 6'b100000, 4'd5);

        // JC taken from a registered carry.
        mem[0]    = 8'h40;
        mem[1]    = 8'h8A;
        alu_carry = 1'b1;
        do_reset();
        obs_fetch("jc_f0", 4'd0);
        obs_exec("jc_e0", 6'b000100, 4'd0);
        alu_carry = 1'b0;
        obs_fetch("jc_f1", 4'd1);
        obs_exec("jc_e1", 6'b000001, 4'hA);
        obs_fetch("jc_tgt", 4'hA);

        // JC not taken: live carry rises after capture and must be ignored.
        do_reset();
        obs_fetch("jnt_f0", 4'd0);
        obs_exec("jnt_e0", 6'b000100, 4'd0);
        alu_carry = 1'b1;
        obs_fetch("jnt_f1", 4'd1);
        obs_exec("jnt_e1", 6'b000000, 4'hA);
        obs_fetch("jnt_f2", 4'd2);

        // JZ taken from a registered zero.
        alu_carry = 1'b0;
        alu_zero  = 1'b1;
        mem[1]    = 8'hA7;
        do_reset();
        obs_fetch("jz_f0", 4'd0);
        obs_exec("jz_e0", 6'b000100, 4'd0);
        alu_zero = 1'b0;
        obs_fetch("jz_f1", 4'd1);
        obs_exec("jz_e1", 6'b000001, 4'd7);
        obs_fetch("jz_tgt", 4'd7);

        // HALT at address 3 is absorbing until reset.
        mem[0] = 8'hD0;
        mem[1] = 8'hD0;
        mem[3] = 8'hC0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            obs_fetch($sformatf("hlt_f%0d", k), 4'(k));
            obs_exec($sformatf("hlt_e%0d", k), 6'b000000, 4'd0);
        end
        obs_fetch("hlt_f3", 4'd3);
        obs_exec("hlt_e3", 6'b000001, 4'd0);
        for (int k = 0; k < 20; k++) begin
            check_val($sformatf("hlt_halted%0d", k), halted, 1'b1);
            check_val($sformatf("hlt_req%0d", k), imem.imem_req, 1'b0);
            check_val($sformatf("hlt_pc%0d", k), pc, 4'd3);
            check_val($sformatf("hlt_strb%0d", k), strobes(), 6'b000000);
            @(negedge clk);
        end
        do_reset();
        obs_fetch("hlt_rst_f0", 4'd0);
        obs_exec("hlt_rst_e0", 6'b000000, 4'd0);

`ifdef CPU_SEQ_SINGLE_STEP_EN
        // Single step: no fetch after EXEC until a step pulse.
        do_reset();
        obs_fetch("ss_f0", 4'd0);
        obs_exec("ss_e0", 6'b000000, 4'd0);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("ss_pause_req%0d", k), imem.imem_req, 1'b0);
            check_val($sformatf("ss_pause_pc%0d", k), pc, 4'd1);
            @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        obs_fetch("ss_f1", 4'd1);
        obs_exec("ss_e1", 6'b000000, 4'd0);
        check_val("ss_pause2_req", imem.imem_req, 1'b0);
        @(negedge clk);
        check_val("ss_pause3_req", imem.imem_req, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port imem_req, output, 1: instruction fetch request.
REQ-004 SHALL have port imem_addr, output, 4: fetch address, equal to PC.
REQ-005 SHALL have port imem_ack, input, 1: fetch acknowledge; imem_data valid in the same cycle.
REQ-006 SHALL have port imem_data, input, 8: instruction word; [7:4] opcode, [3:0] operand.
REQ-007 SHALL have port alu_carry, input, 1: ALU carry result.
REQ-008 SHALL have port alu_zero, input, 1: ALU zero result.
REQ-009 SHALL have ports aload, bload, dsel, rfload, opsel, str, all output, 1: datapath strobes.
REQ-010 SHALL have port operand, output, 4: operand field of the current instruction.
REQ-011 SHALL have port pc, output, 4: current program counter.
REQ-012 SHALL have port halted, output, 1: high while in HALT.

Function
REQ-013 SHALL implement states FETCH, EXEC, HALT.
REQ-014 FETCH SHALL drive imem_req=1 and imem_addr=pc, holding both until imem_ack.
REQ-015 On imem_ack in FETCH, SHALL latch imem_data into IR and enter EXEC next cycle; minimum 2 cycles per instruction.
REQ-016 EXEC SHALL last exactly one cycle; imem_req=0 in EXEC and HALT.
REQ-017 Strobes SHALL equal the decoded control for IR opcode gated by EXEC; all strobes 0 outside EXEC.
REQ-018 Decode table: 0 aload; 1 bload; 2 aload+dsel; 3 bload+dsel; 4 rfload; 5 rfload+opsel; 6,7 jump; 8 jump if carry; 9 jump if !carry; 10 jump if zero; 11 jump if !zero; 12 halt; 13-15 NOP.
REQ-019 Taken jump in EXEC SHALL load pc<=operand and assert str; otherwise pc<=pc+1 modulo 16 (15 wraps to 0).
REQ-020 Conditional jumps SHALL test the registered carry_q/zero_q flags, not the live ALU inputs.
REQ-021 On rfload in EXEC, SHALL capture carry_q<=alu_carry, zero_q<=alu_zero at end of that cycle; flags otherwise held.
REQ-022 Opcode 12 in EXEC SHALL assert str for that cycle, leave pc unchanged, and enter HALT.
REQ-023 HALT SHALL be absorbing until reset; halted=1, all strobes 0.
REQ-024 Opcodes 13-15 and not-taken conditionals SHALL assert no strobes and advance pc by 1.
REQ-025 operand SHALL always reflect IR[3:0].

Reset
REQ-026 rst_n low SHALL immediately force state FETCH, pc=0, IR=0, carry_q=0, zero_q=0, all strobes 0, halted=0.
REQ-027 imem_req SHALL be 0 while rst_n is low; first request asserted in the first cycle after release.
REQ-028 Reset during a pending fetch SHALL abandon it; a late imem_ack is ignored until FETCH is re-entered.

Configuration
REQ-029 Macro CPU_SEQ_SINGLE_STEP_EN SHALL add input step (1) and a state PAUSE entered after each non-halting EXEC.
REQ-030 With the macro, PAUSE SHALL wait for a step=1 cycle, then enter FETCH; without it, EXEC goes directly to FETCH and no step port exists.

Structure
REQ-031 Shared package cpu_pkg SHALL hold opcode constants (OP_LDA..OP_HLT) and the state type.
REQ-032 Decode SHALL be in one sub-module, ins_dec, instantiated once, fed by IR opcode and carry_q/zero_q.

Verification
REQ-033 Reset, then ack immediately on every fetch -> imem_addr 0,1,2,... with one EXEC per 2 cycles.
REQ-034 Program {0x05 at 0} with ack delayed 3 cycles -> imem_req held 4 cycles, aload pulses 1 cycle, operand=5.
REQ-035 rfload with alu_carry=1, then opcode 8 operand 0xA -> pc=0xA, str=1; same with alu_carry=0 -> pc increments.
REQ-036 Opcode 0x0 at address 15 -> next fetch address 0.
REQ-037 Opcode 12 at address 3 -> halted=1, pc stays 3, imem_req stays 0 for 20 cycles; rst_n pulse -> pc=0, fetch resumes.
REQ-038 With CPU_SEQ_SINGLE_STEP_EN -> no fetch after EXEC until step=1; one instruction per step pulse.
